// File: rtl/rs_pkg.sv
// rs_pkg: shared types and helpers for the reservation-station issue scheduler.
//   rsEntry_t   - 144-bit RS entry, MSB first:
//                 [143] valid, [142:111] tag, [110:105] op,
//                 [104] rsFlag, [103:72] rs, [71] rtFlag, [70:39] rt,
//                 [38] rdImmFlag, [37:6] rdImm, [5:0] funct.
//                 An operand flag of 1 means the field holds the value;
//                 0 means it holds the producer tag.
//   OP_*        - opcode constants.
//   needs_rt    - op reads Rt as a source operand.
//   entryReady  - entry has every source operand it needs.
//   wakeup      - apply one CDB broadcast to an entry's waiting operands.
package rs_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [5:0]  op;
    logic        rsFlag;
    logic [31:0] rs;
    logic        rtFlag;
    logic [31:0] rt;
    logic        rdImmFlag;
    logic [31:0] rdImm;
    logic [5:0]  funct;
  } rsEntry_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  function automatic logic needs_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction

  function automatic logic entryReady(input rsEntry_t e);
    return e.rsFlag & (~needs_rt(e.op) | e.rtFlag);
  endfunction

  function automatic rsEntry_t wakeup(input rsEntry_t e, input logic cdbValid,
                                      input logic [31:0] cdbTag,
                                      input logic [31:0] cdbData);
    rsEntry_t w;
    w = e;
    if (cdbValid) begin
      if (!e.rsFlag && e.rs == cdbTag) begin
        w.rs     = cdbData;
        w.rsFlag = 1'b1;
      end
      if (!e.rtFlag && e.rt == cdbTag) begin
        w.rt     = cdbData;
        w.rtFlag = 1'b1;
      end
      if (!e.rdImmFlag && e.rdImm == cdbTag) begin
        w.rdImm     = cdbData;
        w.rdImmFlag = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rs_oldest_ready_picker.sv
// rs_oldest_ready_picker: picks the oldest ready slot.
//   Ready [DEPTH]          - slot is valid and ready to issue.
//   Age   [DEPTH][DEPTH]   - Age[i][j]=1: slot i was allocated before slot j.
//   Grant [DEPTH]          - one-hot winner (zero if nothing ready).
//   Found                  - some slot is ready.
// Age rows of idle slots may be stale; they are harmless because only ready
// slots take part in the comparison, and among valid slots the matrix is a
// strict total order.
module rs_oldest_ready_picker #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            Ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] Age,
  output logic [DEPTH-1:0]            Grant,
  output logic                        Found
);

  for (genvar i = 0; i < DEPTH; i++) begin : gSlot
    logic [DEPTH-1:0] beats;
    always_comb begin
      for (int j = 0; j < DEPTH; j++)
        beats[j] = (j == i) | ~Ready[j] | Age[i][j];
    end
    assign Grant[i] = Ready[i] & (&beats);
  end

  assign Found = |Ready;

endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: reservation-station issue scheduler for one lane.
//   Clk, Reset (sync, active-high)
//   AllocValid/AllocEntry/AllocReady  - dispatch enqueue (AllocReady registered)
//   CdbValid/CdbTag/CdbData           - result broadcast, wakes waiting operands
//   FlushValid/FlushTag               - squash every entry with tag > FlushTag
//   IssueValid/IssueEntry/IssueReady  - registered output stage to the decoder
//   Occupancy                         - occupied slots, output register excluded
// Per-cycle evaluation order: flush, wakeup, select, alloc.
// Build option RS_WAKEUP_BYPASS_EN: selection sees post-wakeup flags, so a
// CDB hit in cycle N can issue at the end of cycle N. Without it, selection
// uses registered flags and a woken entry issues one cycle later.
module rs_issue_scheduler
  import rs_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 144,
  parameter int TAG_W   = 32
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       AllocValid,
  input  logic [ENTRY_W-1:0]         AllocEntry,
  output logic                       AllocReady,
  input  logic                       CdbValid,
  input  logic [TAG_W-1:0]           CdbTag,
  input  logic [TAG_W-1:0]           CdbData,
  input  logic                       FlushValid,
  input  logic [TAG_W-1:0]           FlushTag,
  output logic                       IssueValid,
  output logic [ENTRY_W-1:0]         IssueEntry,
  input  logic                       IssueReady,
  output logic [$clog2(DEPTH):0]     Occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  rsEntry_t [DEPTH-1:0]            slotQ, slotD, woke;
  logic     [DEPTH-1:0][DEPTH-1:0] ageQ;
  rsEntry_t                        issueQ, issueD, selEntry, allocIn, allocWoke;
  logic                            allocReadyQ;
  logic     [OCC_W-1:0]            occQ, occD, flushCnt;

  logic [DEPTH-1:0] flushHit, live, ready, grant;
  logic             found, loadEn, issueLoad, allocWr, issueFlush;
  logic [IDX_W-1:0] freeIdx;

  // Flush, wakeup and readiness per slot.
  for (genvar i = 0; i < DEPTH; i++) begin : gSlot
    assign flushHit[i] = FlushValid & slotQ[i].valid & (slotQ[i].tag > FlushTag);
    assign live[i]     = slotQ[i].valid & ~flushHit[i];
    assign woke[i]     = wakeup(slotQ[i], CdbValid, CdbTag, CdbData);
`ifdef RS_WAKEUP_BYPASS_EN
    assign ready[i]    = live[i] & entryReady(woke[i]);
`else
    assign ready[i]    = live[i] & entryReady(slotQ[i]);
`endif
  end

  rs_oldest_ready_picker #(.DEPTH(DEPTH)) uPicker (
    .Ready (ready),
    .Age   (ageQ),
    .Grant (grant),
    .Found (found)
  );

  assign loadEn     = ~issueQ.valid | IssueReady;
  assign issueLoad  = loadEn & found;
  assign issueFlush = FlushValid & issueQ.valid & (issueQ.tag > FlushTag);

  // Flush wins over a same-cycle alloc of a younger instruction.
  assign allocIn = AllocEntry;
  assign allocWr = AllocValid & allocReadyQ & ~(FlushValid & (allocIn.tag > FlushTag));

  always_comb begin
    allocWoke       = wakeup(allocIn, CdbValid, CdbTag, CdbData);
    allocWoke.valid = 1'b1;
  end

  // Lowest-index slot free in the registered state; a slot vacated this
  // cycle only becomes visible here next cycle.
  always_comb begin
    freeIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!slotQ[i].valid) freeIdx = IDX_W'(i);
  end

  // Issued entry carries any same-cycle wakeup of its remaining operands.
  always_comb begin
    selEntry = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) selEntry = woke[i];
  end

  always_comb begin
    flushCnt = '0;
    for (int i = 0; i < DEPTH; i++) flushCnt = flushCnt + OCC_W'(flushHit[i]);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      slotD[i] = (live[i] & ~(issueLoad & grant[i])) ? woke[i] : '0;
    if (allocWr) slotD[freeIdx] = allocWoke;
  end

  always_comb begin
    issueD = issueQ;
    if (loadEn)          issueD = found ? selEntry : '0;
    else if (issueFlush) issueD = '0;
  end

  assign occD = occQ + OCC_W'(allocWr) - OCC_W'(issueLoad) - flushCnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      slotQ       <= '0;
      ageQ        <= '0;
      issueQ      <= '0;
      occQ        <= '0;
      allocReadyQ <= 1'b1;
    end else begin
      slotQ       <= slotD;
      issueQ      <= issueD;
      occQ        <= occD;
      allocReadyQ <= (occD < OCC_W'(DEPTH));
      // New entry becomes youngest: everyone else is older than it.
      if (allocWr) begin
        for (int j = 0; j < DEPTH; j++) begin
          ageQ[j][freeIdx] <= (IDX_W'(j) != freeIdx);
          ageQ[freeIdx][j] <= 1'b0;
        end
      end
    end
  end

  assign AllocReady = allocReadyQ;
  assign IssueValid = issueQ.valid;
  assign IssueEntry = issueQ;
  assign Occupancy  = occQ;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed scenarios plus randomized traffic, checked
// every cycle against a program-order queue model of the reservation station.
module tb_rs_issue_scheduler;
  import rs_pkg::*;

  localparam int DEPTH = 8;

  logic        Clk = 1'b0;
  logic        Reset, AllocValid, AllocReady, CdbValid, FlushValid;
  logic        IssueValid, IssueReady;
  rsEntry_t    AllocEntry;
  logic [31:0] CdbTag, CdbData, FlushTag;
  logic [143:0] IssueEntry;
  logic [3:0]  Occupancy;
  rsEntry_t    outE;

  assign outE = IssueEntry;

  always #5 Clk = ~Clk;

  rs_issue_scheduler #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .AllocValid(AllocValid), .AllocEntry(AllocEntry), .AllocReady(AllocReady),
    .CdbValid(CdbValid), .CdbTag(CdbTag), .CdbData(CdbData),
    .FlushValid(FlushValid), .FlushTag(FlushTag),
    .IssueValid(IssueValid), .IssueEntry(IssueEntry), .IssueReady(IssueReady),
    .Occupancy(Occupancy)
  );

  int vecCnt = 0;
  int errCnt = 0;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: live entries kept in allocation order, so the oldest
  // ready entry is simply the first ready one in the queue.
  rsEntry_t mQ[$];
  rsEntry_t mOut = '0;
  bit       mAllocRdy = 1'b1;

  function automatic rsEntry_t mWake(input rsEntry_t e);
    if (CdbValid) begin
      if (!e.rsFlag    && e.rs    == CdbTag) begin e.rs    = CdbData; e.rsFlag    = 1'b1; end
      if (!e.rtFlag    && e.rt    == CdbTag) begin e.rt    = CdbData; e.rtFlag    = 1'b1; end
      if (!e.rdImmFlag && e.rdImm == CdbTag) begin e.rdImm = CdbData; e.rdImmFlag = 1'b1; end
    end
    return e;
  endfunction

  function automatic bit mRdy(input rsEntry_t e);
    return e.rsFlag && (e.rtFlag || !(e.op inside {6'h00, 6'h04, 6'h05, 6'h2b}));
  endfunction

  task automatic modelStep();
    rsEntry_t nq[$];
    rsEntry_t e;
    bit ld;
    int pick;
    if (Reset) begin
      mQ.delete(); mOut = '0; mAllocRdy = 1'b1;
      return;
    end
    ld = !mOut.valid || IssueReady;
    if (FlushValid) begin
      foreach (mQ[k]) if (mQ[k].tag <= FlushTag) nq.push_back(mQ[k]);
      mQ = nq;
      if (!ld && mOut.valid && mOut.tag > FlushTag) mOut = '0;
    end
    pick = -1;
    if (ld) begin
      foreach (mQ[k]) begin
`ifdef RS_WAKEUP_BYPASS_EN
        if (pick < 0 && mRdy(mWake(mQ[k]))) pick = k;
`else
        if (pick < 0 && mRdy(mQ[k])) pick = k;
`endif
      end
    end
    foreach (mQ[k]) mQ[k] = mWake(mQ[k]);
    if (ld) begin
      if (pick >= 0) begin
        mOut = mQ[pick];
        mQ.delete(pick);
      end else mOut = '0;
    end
    if (AllocValid && mAllocRdy && !(FlushValid && AllocEntry.tag > FlushTag)) begin
      e = mWake(AllocEntry);
      e.valid = 1'b1;
      mQ.push_back(e);
    end
    mAllocRdy = (mQ.size() < DEPTH);
  endtask

  task automatic tick();
    @(posedge Clk);
    modelStep();
    #1;
    chk("IssueValid", IssueValid, mOut.valid);
    chk("IssueEntry", IssueEntry, mOut);
    chk("Occupancy", Occupancy, mQ.size());
    chk("AllocReady", AllocReady, mAllocRdy);
  endtask

  task automatic idle();
    Reset = 0; AllocValid = 0; AllocEntry = '0; CdbValid = 0; CdbTag = 0;
    CdbData = 0; FlushValid = 0; FlushTag = 0; IssueReady = 1;
  endtask

  task automatic doReset();
    idle(); Reset = 1; tick(); Reset = 0;
  endtask

  function automatic rsEntry_t mk(input int tag, input logic [5:0] op, input logic rsF,
                                  input int rs, input logic rtF, input int rt);
    rsEntry_t e;
    e = '0;
    e.valid = 1'b1; e.tag = tag; e.op = op;
    e.rsFlag = rsF; e.rs = rs; e.rtFlag = rtF; e.rt = rt;
    e.rdImmFlag = 1'b1; e.rdImm = 32'h1234; e.funct = 6'h20;
    return e;
  endfunction

  function automatic rsEntry_t rnd();
    rsEntry_t e;
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'h00; 1: op = 6'h04; 2: op = 6'h05; 3: op = 6'h23;
      4: op = 6'h2b; 5: op = 6'h08; default: op = 6'h0f;
    endcase
    e.valid     = 1'b1;
    e.tag       = $urandom_range(0, 63);
    e.op        = op;
    e.rsFlag    = ($urandom_range(0, 9) < 6);
    e.rs        = e.rsFlag ? $urandom : $urandom_range(0, 63);
    e.rtFlag    = ($urandom_range(0, 9) < 6);
    e.rt        = e.rtFlag ? $urandom : $urandom_range(0, 63);
    e.rdImmFlag = $urandom_range(0, 1);
    e.rdImm     = e.rdImmFlag ? $urandom : $urandom_range(0, 63);
    e.funct     = 6'($urandom);
    return e;
  endfunction

  initial begin
    idle();
    doReset();
    chk("rstIssue", IssueEntry, 144'h0);
    chk("rstAllocReady", AllocReady, 1);

    // Simple ready add issues the cycle after it lands in a slot.
    doReset();
    AllocValid = 1; AllocEntry = mk(5, 6'h00, 1, 3, 1, 4); tick();
    idle(); tick();
    chk("addValid", IssueValid, 1);
    chk("addTag", outE.tag, 5);
    chk("addOcc", Occupancy, 0);

    // Younger ready entry bypasses an older waiting one; CDB then wakes it.
    doReset();
    AllocValid = 1; AllocEntry = mk(10, 6'h00, 0, 7, 1, 2); tick();
    AllocEntry = mk(11, 6'h00, 1, 1, 1, 2); tick();
    idle(); tick();
    chk("firstTag11", outE.tag, 11);
    CdbValid = 1; CdbTag = 7; CdbData = 32'h55; tick();
    idle();
`ifndef RS_WAKEUP_BYPASS_EN
    chk("wakeBubble", IssueValid, 0);
    tick();
`endif
    chk("wakeTag", outE.tag, 10);
    chk("wakeRs", outE.rs, 32'h55);
    chk("wakeFlag", outE.rsFlag, 1);

    // Fill all slots with waiting entries; a ninth alloc is ignored.
    doReset();
    for (int k = 0; k < DEPTH; k++) begin
      AllocValid = 1; AllocEntry = mk(30 + k, 6'h00, 0, 40 + k, 1, 0); tick();
    end
    chk("fullOcc", Occupancy, DEPTH);
    chk("fullRdy", AllocReady, 0);
    AllocEntry = mk(38, 6'h00, 1, 0, 1, 0); tick();
    chk("ninthOcc", Occupancy, DEPTH);
    idle(); CdbValid = 1; CdbTag = 40; CdbData = 1; tick();
    idle();
`ifndef RS_WAKEUP_BYPASS_EN
    chk("stillFull", AllocReady, 0);
    tick();
`endif
    chk("freedRdy", AllocReady, 1);
    chk("freedTag", outE.tag, 30);
    for (int k = 1; k < DEPTH; k++) begin
      CdbValid = 1; CdbTag = 40 + k; tick();
    end
    idle();
    for (int k = 0; k < 3; k++) tick();

    // Stall holds the output; release shows the next-oldest ready entry.
    doReset();
    IssueReady = 0;
    for (int k = 0; k < 3; k++) begin
      AllocValid = 1; AllocEntry = mk(50 + k, 6'h08, 1, k, 0, 0); tick();
    end
    idle(); IssueReady = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stallTag", outE.tag, 50);
    end
    IssueReady = 1; tick();
    chk("releaseTag", outE.tag, 51);
    tick(); tick();

    // Flush squashes younger slots and a same-cycle younger alloc.
    doReset();
    for (int k = 0; k < 4; k++) begin
      AllocValid = 1; AllocEntry = mk(20 + k, 6'h00, 0, 99, 1, 0); tick();
    end
    AllocEntry = mk(24, 6'h00, 1, 0, 1, 0); FlushValid = 1; FlushTag = 21; tick();
    idle();
    chk("flushOcc", Occupancy, 2);
    tick();
    chk("flushNoIssue", IssueValid, 0);
    CdbValid = 1; CdbTag = 99; tick();
    idle();
    for (int k = 0; k < 3; k++) tick();

    // Addi ignores Rt; Sw waits for it.
    doReset();
    AllocValid = 1; AllocEntry = mk(60, 6'h08, 1, 1, 0, 77); tick();
    AllocEntry = mk(61, 6'h2b, 1, 1, 0, 78); tick();
    idle(); tick();
    chk("swWaits", IssueValid, 0);
    chk("swOcc", Occupancy, 1);
    CdbValid = 1; CdbTag = 78; CdbData = 32'hABCD; tick();
    idle();
    for (int k = 0; k < 3; k++) tick();

    // Randomized traffic, including occasional mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      Reset      = ($urandom_range(0, 299) == 0);
      AllocValid = $urandom_range(0, 1);
      AllocEntry = rnd();
      CdbValid   = ($urandom_range(0, 9) < 4);
      CdbTag     = $urandom_range(0, 63);
      CdbData    = $urandom;
      FlushValid = ($urandom_range(0, 19) == 0);
      FlushTag   = $urandom_range(0, 63);
      IssueReady = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
